// File: rtl/seg_pkg.sv
// Shared seven-segment types, the blank pattern and the anode one-hot helper
// used by the scan driver and its character decoder.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Segment order is {g,f,e,d,c,b,a}; a set bit lights the segment.
  localparam seg_t SEG_OFF     = 7'b0000000;
  localparam seg_t SEG_DEFAULT = 7'b1000000;

  localparam int MAX_DIGITS = 32;

  function automatic logic [MAX_DIGITS-1:0] anode_onehot(input int unsigned idx);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_decoder.sv
// Combinational character-to-segment decoder: codes 0..9 map to decimal
// glyphs, anything else shows a centre dash.
module DisplayDecoder
  import seg_pkg::*;
#(
  parameter int CHAR_W = 4
) (
  input  logic [CHAR_W-1:0] char_sel,
  output seg_t              segments
);

  logic [31:0] code;

  always_comb begin
    code     = 32'(char_sel);
    segments = SEG_DEFAULT;
    case (code)
      32'd0:   segments = 7'h3F;
      32'd1:   segments = 7'h06;
      32'd2:   segments = 7'h5B;
      32'd3:   segments = 7'h4F;
      32'd4:   segments = 7'h66;
      32'd5:   segments = 7'h6D;
      32'd6:   segments = 7'h7D;
      32'd7:   segments = 7'h07;
      32'd8:   segments = 7'h7F;
      32'd9:   segments = 7'h6F;
      default: segments = SEG_DEFAULT;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Round-robin scan driver for an N-digit seven-segment display with a shadow
// character register, per-digit blank and blink, and an anti-ghosting dead time.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CHAR_W        = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int DEAD_CYCLES   = 8,
  parameter int BLINK_FRAMES  = 64,
  parameter int AN_ACTIVE_LOW = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         load,
  input  logic [NUM_DIGITS*CHAR_W-1:0] char_bus,
  input  logic [NUM_DIGITS-1:0]        blank_mask,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  output logic [6:0]                   segments,
  output logic [NUM_DIGITS-1:0]        anodes,
  output logic [IDX_W-1:0]             digit_idx
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [RC_W-1:0]       RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [RC_W-1:0]       DEAD_CNT = RC_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{(AN_ACTIVE_LOW != 0)}};

  logic [RC_W-1:0]   refresh_cnt;
  logic [FC_W-1:0]   frame_cnt;
  logic              blink_phase;
  logic [CHAR_W-1:0] shadow [NUM_DIGITS];

  logic [CHAR_W-1:0]     cur_char;
  seg_t                  dec_seg;
  logic                  slot_end;
  logic                  last_digit;
  logic                  in_dead;
  logic [MAX_DIGITS-1:0] onehot_all;
  seg_t                  seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign cur_char = shadow[digit_idx];

  DisplayDecoder #(.CHAR_W(CHAR_W)) u_decoder (
    .char_sel (cur_char),
    .segments (dec_seg)
  );

  // XOR with the idle level turns the active-high one-hot into the pin polarity.
  always_comb begin
    slot_end   = (refresh_cnt == RC_LAST);
    last_digit = (digit_idx == IDX_LAST);
    in_dead    = (refresh_cnt < DEAD_CNT);
    onehot_all = anode_onehot(32'(digit_idx));
    an_next    = AN_IDLE;
    seg_next   = SEG_OFF;
    if (enable && !in_dead) begin
      an_next = onehot_all[NUM_DIGITS-1:0] ^ AN_IDLE;
      if (!blank_mask[digit_idx] && !(blink_mask[digit_idx] && blink_phase))
        seg_next = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!enable) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (slot_end) begin
      refresh_cnt <= '0;
      digit_idx   <= last_digit ? '0 : digit_idx + 1'b1;
      if (last_digit) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Shadow loads are independent of enable so characters can be staged while dark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= char_bus[k*CHAR_W +: CHAR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segments <= SEG_OFF;
      anodes   <= AN_IDLE;
    end else begin
      segments <= seg_next;
      anodes   <= an_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: a cycle-count reference model
// predicts anodes, segments and digit index from slot/frame arithmetic.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] char_bus;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [6:0]  segments;
  logic [3:0]  anodes;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;

  int         n;
  logic [3:0] sh [4];
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic [1:0] exp_idx;

  seven_seg_scan_driver #(
    .NUM_DIGITS    (4),
    .CHAR_W        (4),
    .REFRESH_DIV   (4),
    .DEAD_CYCLES   (1),
    .BLINK_FRAMES  (2),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .char_bus   (char_bus),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .segments   (segments),
    .anodes     (anodes),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] deco(input logic [3:0] c);
    case (c)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // n counts enabled cycles since the last clear; slot = n/4, frame = n/16,
  // blink half-period = 2 frames = 32 cycles.
  task automatic tick();
    int pos, dig, ph;
    if (!rst_n) begin
      exp_seg = 7'h00;
      exp_an  = 4'hF;
      n       = 0;
      for (int k = 0; k < 4; k++) sh[k] = 4'h0;
    end else begin
      pos = n % 4;
      dig = (n / 4) % 4;
      ph  = (n / 32) % 2;
      if (!enable || pos < 1) begin
        exp_seg = 7'h00;
        exp_an  = 4'hF;
      end else begin
        exp_an  = ~(4'b0001 << dig);
        exp_seg = (blank_mask[dig] || (blink_mask[dig] && ph == 1)) ? 7'h00 : deco(sh[dig]);
      end
      if (load) for (int k = 0; k < 4; k++) sh[k] = char_bus[k*4 +: 4];
      n = enable ? n + 1 : 0;
    end
    exp_idx = 2'((n / 4) % 4);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    char_bus = 16'h0; blank_mask = 4'h0; blink_mask = 4'h0;
    repeat (3) tick();
    checks++; if (anodes !== 4'b1111) begin errors++; $display("[TB] FAIL reset_anodes got %b want %b", anodes, 4'b1111); end
    checks++; if (segments !== 7'b0) begin errors++; $display("[TB] FAIL reset_segments got %h want %h", segments, 7'h00); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", digit_idx); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    enable = 1'b1; load = 1'b1; char_bus = 16'h3210;
    tick();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++; if (anodes !== exp_an) begin errors++; $display("[TB] FAIL scan_anodes cyc %0d got %b want %b", i, anodes, exp_an); end
      checks++; if (segments !== exp_seg) begin errors++; $display("[TB] FAIL scan_segments cyc %0d got %h want %h", i, segments, exp_seg); end
      checks++; if (digit_idx !== exp_idx) begin errors++; $display("[TB] FAIL scan_idx cyc %0d got %0d want %0d", i, digit_idx, exp_idx); end
    end
  endtask

  task automatic test_blank();
    blank_mask = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if (anodes !== exp_an) begin errors++; $display("[TB] FAIL blank_anodes cyc %0d got %b want %b", i, anodes, exp_an); end
      checks++; if (segments !== exp_seg) begin errors++; $display("[TB] FAIL blank_segments cyc %0d got %h want %h", i, segments, exp_seg); end
    end
    blank_mask = 4'b0000;
  endtask

  task automatic test_blink();
    blink_mask = 4'b0001;
    for (int i = 0; i < 144; i++) begin
      tick();
      checks++; if (anodes !== exp_an) begin errors++; $display("[TB] FAIL blink_anodes cyc %0d got %b want %b", i, anodes, exp_an); end
      checks++; if (segments !== exp_seg) begin errors++; $display("[TB] FAIL blink_segments cyc %0d got %h want %h", i, segments, exp_seg); end
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_load_on_slot_change();
    for (int i = 0; i < 8 && (n % 4) != 3; i++) tick();
    load = 1'b1; char_bus = 16'hF876;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (anodes !== exp_an) begin errors++; $display("[TB] FAIL load_anodes cyc %0d got %b want %b", i, anodes, exp_an); end
      checks++; if (segments !== exp_seg) begin errors++; $display("[TB] FAIL load_segments cyc %0d got %h want %h", i, segments, exp_seg); end
    end
  endtask

  task automatic test_reset_mid_slot();
    for (int i = 0; i < 20 && (n % 16) != 10; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (anodes !== 4'b1111) begin errors++; $display("[TB] FAIL midrst_anodes got %b want %b", anodes, 4'b1111); end
    checks++; if (segments !== 7'b0) begin errors++; $display("[TB] FAIL midrst_segments got %h want %h", segments, 7'h00); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("[TB] FAIL midrst_idx got %0d want 0", digit_idx); end
    rst_n = 1'b1; enable = 1'b0; load = 1'b1; char_bus = 16'h5947;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (anodes !== 4'b1111) begin errors++; $display("[TB] FAIL dark_anodes cyc %0d got %b want %b", i, anodes, 4'b1111); end
      checks++; if (segments !== 7'b0) begin errors++; $display("[TB] FAIL dark_segments cyc %0d got %h want %h", i, segments, 7'h00); end
      checks++; if (digit_idx !== 2'd0) begin errors++; $display("[TB] FAIL dark_idx cyc %0d got %0d want 0", i, digit_idx); end
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (anodes !== exp_an) begin errors++; $display("[TB] FAIL restart_anodes cyc %0d got %b want %b", i, anodes, exp_an); end
      checks++; if (segments !== exp_seg) begin errors++; $display("[TB] FAIL restart_segments cyc %0d got %h want %h", i, segments, exp_seg); end
      checks++; if (digit_idx !== exp_idx) begin errors++; $display("[TB] FAIL restart_idx cyc %0d got %0d want %0d", i, digit_idx, exp_idx); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load       = ($urandom_range(0, 7) == 0);
      char_bus   = 16'($urandom);
      enable     = ($urandom_range(0, 39) != 0);
      rst_n      = ($urandom_range(0, 149) != 0);
      if ((i % 50) == 0) begin
        blank_mask = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      tick();
      checks++; if (anodes !== exp_an) begin errors++; $display("[TB] FAIL rand_anodes cyc %0d got %b want %b", i, anodes, exp_an); end
      checks++; if (segments !== exp_seg) begin errors++; $display("[TB] FAIL rand_segments cyc %0d got %h want %h", i, segments, exp_seg); end
      checks++; if (digit_idx !== exp_idx) begin errors++; $display("[TB] FAIL rand_idx cyc %0d got %0d want %0d", i, digit_idx, exp_idx); end
    end
  endtask

  initial begin
    n = 0;
    for (int k = 0; k < 4; k++) sh[k] = 4'h0;
    test_reset();
    test_scan();
    test_blank();
    test_blink();
    test_load_on_slot_change();
    test_reset_mid_slot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
